// File: rtl/alu_pkg.sv
// Shared types for the sliced ripple ALU: opcodes, result flags and sequencer states.
package alu_pkg;

    typedef enum logic [2:0] {
        OpNop = 3'd0,
        OpAdc = 3'd1,
        OpSbc = 3'd2,
        OpAnd = 3'd3,
        OpOrr = 3'd4,
        OpEor = 3'd5,
        OpSel = 3'd6,
        OpSeh = 3'd7
    } op_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/alu_slice.sv
// One combinational SLICE-bit ALU step. Carry passes straight through for non-arithmetic ops.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 2
) (
    input  op_t              op,
    input  logic             cin,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] r,
    output logic             cout,
    output logic             zero
);

    logic [SLICE-1:0] w_b;
    logic [SLICE:0]   w_sum;

    // Shared adder for ADC and SBC (SBC is A + ~B + cin), then select the op result.
    always_comb begin
        w_b   = (op == OpSbc) ? ~b : b;
        w_sum = {1'b0, a} + {1'b0, w_b} + {{SLICE{1'b0}}, cin};
        r     = '0;
        cout  = cin;
        unique case (op)
            OpNop: r = '0;
            OpAdc: begin
                r    = w_sum[SLICE-1:0];
                cout = w_sum[SLICE];
            end
            OpSbc: begin
                r    = w_sum[SLICE-1:0];
                cout = w_sum[SLICE];
            end
            OpAnd: r = a & b;
            OpOrr: r = a | b;
            OpEor: r = a ^ b;
            OpSel: r = a;
            OpSeh: r = b;
        endcase
        zero = ~|r;
    end

endmodule

// File: rtl/slice_alu_seq.sv
// Multi-cycle ripple ALU: one SLICE-bit slice per enabled cycle, LSB first, carry registered
// between slices. Valid/ready handshake on request and result sides.
module slice_alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_enable,
    input  logic             rx_valid,
    output logic             tx_ready,
    input  logic [2:0]       rx_opcode,
    input  logic             rx_carryflag,
    input  logic [WIDTH-1:0] rx_operand0,
    input  logic [WIDTH-1:0] rx_operand1,
    output logic             tx_valid,
    input  logic             rx_result_ready,
    output logic [WIDTH-1:0] tx_result,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
    output logic             tx_signflag,
    output logic             tx_overflowflag
);

    localparam int unsigned NSLICE = (SLICE == 0) ? 1 : WIDTH / SLICE;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (SLICE == 0 || (WIDTH % ((SLICE == 0) ? 1 : SLICE)) != 0) begin : g_bad_slice
        $error("slice_alu_seq: SLICE must be >= 1 and divide WIDTH");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [KW-1:0]    r_k;
    op_t              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_cin;
    logic             r_zacc;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;

    logic             w_accept;
    logic             w_consume;
    logic             w_last;
    logic [IW-1:0]    w_base;
    logic [SLICE-1:0] w_sr;
    logic             w_scout;
    logic             w_szero;
    logic [WIDTH-1:0] w_final;
    logic             w_bmsb;
    logic             w_arith;

    assign tx_valid  = (r_state == StDone);
    assign tx_ready  = (r_state == StIdle) | ((r_state == StDone) & rx_result_ready);
    assign w_accept  = rx_valid & tx_ready & rx_enable;
    assign w_consume = tx_valid & rx_result_ready & rx_enable;
    assign w_last    = (r_k == KW'(NSLICE - 1));
    assign w_base    = IW'(r_k * SLICE);
    assign w_arith   = (r_op == OpAdc) | (r_op == OpSbc);
    assign w_bmsb    = (r_op == OpSbc) ? ~r_b[WIDTH-1] : r_b[WIDTH-1];

    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op   (r_op),
        .cin  (r_cin),
        .a    (r_a[w_base +: SLICE]),
        .b    (r_b[w_base +: SLICE]),
        .r    (w_sr),
        .cout (w_scout),
        .zero (w_szero)
    );

    // Full result as it will look once the current slice is written.
    always_comb begin
        w_final                  = r_acc;
        w_final[w_base +: SLICE] = w_sr;
    end

    // Next-state logic; a request on the consume edge chains straight into RUN.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = StRun;
            StRun:  if (w_last) w_state_next = StDone;
            StDone: if (w_consume) w_state_next = w_accept ? StRun : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register, frozen while rx_enable is low.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= StIdle;
        end else if (rx_enable) begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, per-slice accumulation and the published result/flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_k      <= '0;
            r_op     <= OpNop;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cin    <= 1'b0;
            r_zacc   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (rx_enable) begin
            if (w_accept) begin
                r_op   <= op_t'(rx_opcode);
                r_a    <= rx_operand0;
                r_b    <= rx_operand1;
                r_cin  <= rx_carryflag;
                r_k    <= '0;
                r_zacc <= 1'b1;
            end else if (r_state == StRun) begin
                r_acc[w_base +: SLICE] <= w_sr;
                r_cin                  <= w_scout;
                r_zacc                 <= r_zacc & w_szero;
                r_k                    <= w_last ? '0 : r_k + KW'(1);
                if (w_last) begin
                    r_result  <= w_final;
                    r_flags.c <= w_scout;
                    r_flags.z <= r_zacc & w_szero;
                    r_flags.n <= w_final[WIDTH-1];
                    r_flags.v <= w_arith & (r_a[WIDTH-1] == w_bmsb)
                                 & (w_final[WIDTH-1] != r_a[WIDTH-1]);
                end
            end
        end
    end

    assign tx_result       = r_result;
    assign tx_carryflag    = r_flags.c;
    assign tx_zeroflag     = r_flags.z;
    assign tx_signflag     = r_flags.n;
    assign tx_overflowflag = r_flags.v;

endmodule

// File: tb/tb_slice_alu_seq.sv
// Self-checking bench for slice_alu_seq against a whole-word arithmetic reference model.
module tb_slice_alu_seq;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SLICE  = 2;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    logic        aclk            = 1'b0;
    logic        aresetn         = 1'b0;
    logic        rx_enable       = 1'b1;
    logic        rx_valid        = 1'b0;
    logic [2:0]  rx_opcode       = 3'd0;
    logic        rx_carryflag    = 1'b0;
    logic [15:0] rx_operand0     = 16'h0;
    logic [15:0] rx_operand1     = 16'h0;
    logic        rx_result_ready = 1'b0;
    logic        tx_ready;
    logic        tx_valid;
    logic [15:0] tx_result;
    logic        tx_carryflag;
    logic        tx_zeroflag;
    logic        tx_signflag;
    logic        tx_overflowflag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    slice_alu_seq #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .rx_enable       (rx_enable),
        .rx_valid        (rx_valid),
        .tx_ready        (tx_ready),
        .rx_opcode       (rx_opcode),
        .rx_carryflag    (rx_carryflag),
        .rx_operand0     (rx_operand0),
        .rx_operand1     (rx_operand1),
        .tx_valid        (tx_valid),
        .rx_result_ready (rx_result_ready),
        .tx_result       (tx_result),
        .tx_carryflag    (tx_carryflag),
        .tx_zeroflag     (tx_zeroflag),
        .tx_signflag     (tx_signflag),
        .tx_overflowflag (tx_overflowflag)
    );

    // Reference: whole-word result {result, C, Z, N, V}.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] r;
        logic [15:0] bb;
        logic        c;
        logic        v;
        c  = cin;
        v  = 1'b0;
        r  = 16'h0;
        bb = (op == 3'd2) ? ~b : b;
        case (op)
            3'd1, 3'd2: begin
                s = {1'b0, a} + {1'b0, bb} + {16'h0, cin};
                r = s[15:0];
                c = s[16];
                v = (a[15] == bb[15]) && (r[15] != a[15]);
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = a;
            3'd7: r = b;
            default: r = 16'h0;
        endcase
        return {r, c, (r == 16'h0), r[15], v};
    endfunction

    function automatic logic [19:0] obs();
        return {tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_overflowflag};
    endfunction

    // Present one request at a negedge while idle; returns edges from accept to tx_valid.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic c, output int lat);
        rx_opcode    = op;
        rx_operand0  = a;
        rx_operand1  = b;
        rx_carryflag = c;
        rx_valid     = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rx_valid = 1'b0;
        lat      = 0;
        while (tx_valid !== 1'b1 && lat < 64) begin
            @(negedge aclk);
            lat++;
        end
    endtask

    task automatic consume();
        rx_result_ready = 1'b1;
        @(negedge aclk);
        rx_result_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        n_checks++;
        if ({obs(), tx_valid, tx_ready} !== {20'h0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected %h", {obs(), tx_valid, tx_ready},
                     {20'h0, 1'b0, 1'b1});
        end
        aresetn = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({obs(), tx_valid, tx_ready} !== {20'h0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected %h", {obs(), tx_valid, tx_ready},
                     {20'h0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops[6] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd5, 3'd7};
        logic [15:0] as[6]  = '{16'h7FFF, 16'h0005, 16'h0000, 16'hFFFF, 16'hA5A5, 16'h1234};
        logic [15:0] bs[6]  = '{16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'hFFFF, 16'hBEEF};
        logic        cs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [19:0] exp;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            exp = model(ops[i], as[i], bs[i], cs[i]);
            issue(ops[i], as[i], bs[i], cs[i], lat);
            n_checks++;
            if (lat != NSLICE) begin
                n_errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NSLICE);
            end
            n_checks++;
            if (obs() !== exp || tx_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL directed_result[%0d]: got %h ready %b expected %h ready 0",
                         i, obs(), tx_ready, exp);
            end
            if (i == 0) begin
                n_checks++;
                if (obs() !== {16'h8000, 4'b0011}) begin
                    n_errors++;
                    $display("FAIL adc_overflow_literal: got %h expected %h", obs(),
                             {16'h8000, 4'b0011});
                end
            end
            consume();
            n_checks++;
            if ({tx_valid, tx_ready, obs()} !== {1'b0, 1'b1, exp}) begin
                n_errors++;
                $display("FAIL directed_idle_hold[%0d]: got %h expected %h", i,
                         {tx_valid, tx_ready, obs()}, {1'b0, 1'b1, exp});
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [19:0] exp;
        int          lat;
        for (int i = 0; i < 30; i++) begin
            op  = 3'($urandom_range(7, 0));
            a   = 16'($urandom);
            b   = 16'($urandom);
            c   = 1'($urandom);
            exp = model(op, a, b, c);
            issue(op, a, b, c, lat);
            n_checks++;
            if (lat != NSLICE || obs() !== exp) begin
                n_errors++;
                $display("FAIL random[%0d] op%0d: got lat %0d %h expected lat %0d %h",
                         i, op, lat, obs(), NSLICE, exp);
            end
            repeat ($urandom_range(2, 0)) @(negedge aclk);
            consume();
        end
    endtask

    // Requests during RUN and during an unconsumed DONE must be ignored.
    task automatic test_hold();
        logic [19:0] exp;
        int          lat;
        exp          = model(3'd1, 16'h1111, 16'h2222, 1'b1);
        rx_opcode    = 3'd1;
        rx_operand0  = 16'h1111;
        rx_operand1  = 16'h2222;
        rx_carryflag = 1'b1;
        rx_valid     = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rx_opcode   = 3'd5;
        rx_operand0 = 16'($urandom);
        lat         = 0;
        while (tx_valid !== 1'b1 && lat < 64) begin
            @(negedge aclk);
            lat++;
        end
        n_checks++;
        if (lat != NSLICE || obs() !== exp) begin
            n_errors++;
            $display("FAIL hold_ignore_run: got lat %0d %h expected lat %0d %h", lat, obs(),
                     NSLICE, exp);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            n_checks++;
            if ({tx_valid, tx_ready, obs()} !== {1'b1, 1'b0, exp}) begin
                n_errors++;
                $display("FAIL hold_done[%0d]: got %h expected %h", i,
                         {tx_valid, tx_ready, obs()}, {1'b1, 1'b0, exp});
            end
        end
        rx_valid = 1'b0;
        consume();
        n_checks++;
        if ({tx_valid, tx_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL hold_consume: got %b expected 01", {tx_valid, tx_ready});
        end
    endtask

    // Held request and ready: each consume edge also accepts the next op.
    task automatic test_back_to_back();
        logic [2:0]  ops[4];
        logic [15:0] as[4];
        logic [15:0] bs[4];
        logic        cs[4];
        logic [19:0] exp[4];
        logic        want_valid;
        int          idx;
        for (int i = 0; i < 4; i++) begin
            ops[i] = 3'($urandom_range(7, 0));
            as[i]  = 16'($urandom);
            bs[i]  = 16'($urandom);
            cs[i]  = 1'($urandom);
            exp[i] = model(ops[i], as[i], bs[i], cs[i]);
        end
        rx_opcode       = ops[0];
        rx_operand0     = as[0];
        rx_operand1     = bs[0];
        rx_carryflag    = cs[0];
        rx_valid        = 1'b1;
        rx_result_ready = 1'b1;
        @(posedge aclk);
        for (int t = 0; t < 4 * (NSLICE + 1); t++) begin
            @(negedge aclk);
            want_valid = ((t % (NSLICE + 1)) == NSLICE);
            n_checks++;
            if ({tx_valid, tx_ready} !== {want_valid, want_valid}) begin
                n_errors++;
                $display("FAIL b2b_valid_t%0d: got %b expected %b", t, {tx_valid, tx_ready},
                         {want_valid, want_valid});
            end
            if (want_valid) begin
                idx = t / (NSLICE + 1);
                n_checks++;
                if (obs() !== exp[idx]) begin
                    n_errors++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", idx, obs(), exp[idx]);
                end
            end
            if ((t % (NSLICE + 1)) == 0) begin
                idx = t / (NSLICE + 1) + 1;
                if (idx < 4) begin
                    rx_opcode    = ops[idx];
                    rx_operand0  = as[idx];
                    rx_operand1  = bs[idx];
                    rx_carryflag = cs[idx];
                end else begin
                    rx_valid = 1'b0;
                end
            end
        end
        @(negedge aclk);
        rx_result_ready = 1'b0;
        n_checks++;
        if ({tx_valid, tx_ready, obs()} !== {1'b0, 1'b1, exp[3]}) begin
            n_errors++;
            $display("FAIL b2b_drain: got %h expected %h", {tx_valid, tx_ready, obs()},
                     {1'b0, 1'b1, exp[3]});
        end
    endtask

    task automatic test_enable_freeze();
        logic [19:0] prev;
        logic [19:0] exp;
        int          t;
        prev         = obs();
        exp          = model(3'd1, 16'h1234, 16'h1111, 1'b0);
        rx_opcode    = 3'd1;
        rx_operand0  = 16'h1234;
        rx_operand1  = 16'h1111;
        rx_carryflag = 1'b0;
        rx_valid     = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rx_valid = 1'b0;
        t        = 0;
        while (tx_valid !== 1'b1 && t < 64) begin
            if (t >= 4 && t <= 6) begin
                n_checks++;
                if (obs() !== prev) begin
                    n_errors++;
                    $display("FAIL freeze_stable_t%0d: got %h expected %h", t, obs(), prev);
                end
            end
            if (t == 3) rx_enable = 1'b0;
            if (t == 6) rx_enable = 1'b1;
            @(negedge aclk);
            t++;
        end
        n_checks++;
        if (t != NSLICE + 3 || obs() !== exp) begin
            n_errors++;
            $display("FAIL freeze_latency: got lat %0d %h expected lat %0d %h", t, obs(),
                     NSLICE + 3, exp);
        end
        // Consumer ready but clock-enable low: nothing is consumed.
        rx_enable       = 1'b0;
        rx_result_ready = 1'b1;
        repeat (2) @(negedge aclk);
        n_checks++;
        if ({tx_valid, obs()} !== {1'b1, exp}) begin
            n_errors++;
            $display("FAIL freeze_done: got %h expected %h", {tx_valid, obs()}, {1'b1, exp});
        end
        rx_enable = 1'b1;
        @(negedge aclk);
        rx_result_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL freeze_consume: got %b expected 0", tx_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [19:0] exp;
        int          lat;
        rx_opcode    = 3'd1;
        rx_operand0  = 16'hF0F0;
        rx_operand1  = 16'h0F0F;
        rx_carryflag = 1'b1;
        rx_valid     = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rx_valid = 1'b0;
        repeat (4) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        n_checks++;
        if ({obs(), tx_valid, tx_ready} !== {20'h0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected %h", {obs(), tx_valid, tx_ready},
                     {20'h0, 1'b0, 1'b1});
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        exp = model(3'd1, 16'h0001, 16'h0001, 1'b0);
        issue(3'd1, 16'h0001, 16'h0001, 1'b0, lat);
        n_checks++;
        if (lat != NSLICE || obs() !== {16'h0002, 4'b0000} || obs() !== exp) begin
            n_errors++;
            $display("FAIL post_reset_adc: got lat %0d %h expected lat %0d %h", lat, obs(),
                     NSLICE, {16'h0002, 4'b0000});
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_enable_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
